izhikevich_array: RTL and testbench

IZHIKEVICH_ARRAY -- requirements
Module: izhikevich_array

---
 rtl/izhikevich_array.sv | 161 ++++++++++++++++
 tb/tb_izhikevich_array.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izhikevich_array.sv
// Time-multiplexed Izhikevich neuron array: one fixed-point datapath sweeps all
// neurons per timestep, fetching each neuron's input current through a request/valid handshake.
module izhikevich_array #(
  parameter int N            = 32,
  parameter int Q            = 16,
  parameter int NUM_NEURONS  = 8,
  parameter int REFRAC_STEPS = 0,
  parameter int IDX_W        = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     v_init,
  input  logic [N-1:0]     w_init,
  input  logic [N-1:0]     v_th,
  input  logic [N-1:0]     step,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     c,
  input  logic [N-1:0]     d,
  output logic             i_req,
  output logic [IDX_W-1:0] i_idx,
  input  logic [N-1:0]     i_data,
  input  logic             i_valid,
  output logic             spike,
  output logic [IDX_W-1:0] spike_idx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      timestep,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [N-1:0]     rd_v,
  output logic [N-1:0]     rd_w
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int RC_W = $clog2(REFRAC_STEPS + 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  localparam logic signed [N-1:0] K_004 = N'((64'sd4 <<< Q) / 64'sd100);
  localparam logic signed [N-1:0] K_5   = N'(64'sd5 <<< Q);
  localparam logic signed [N-1:0] K_140 = N'(64'sd140 <<< Q);
  localparam logic signed [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};

  function automatic logic signed [N-1:0] mul_q(input logic signed [N-1:0] x,
                                                input logic signed [N-1:0] y);
    logic signed [2*N-1:0] p;
    p = x * y;
    p = p >>> Q;
    return p[N-1:0];
  endfunction

  // Overflow shows as disagreement between the extra sign bit and the MSB.
  function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] x,
                                                  input logic signed [N-1:0] y);
    logic signed [N:0] s;
    s = (N+1)'(x) + (N+1)'(y);
    if (s[N] != s[N-1]) return s[N] ? S_MIN : S_MAX;
    return s[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] sat_sub(input logic signed [N-1:0] x,
                                                  input logic signed [N-1:0] y);
    logic signed [N:0] s;
    s = (N+1)'(x) - (N+1)'(y);
    if (s[N] != s[N-1]) return s[N] ? S_MIN : S_MAX;
    return s[N-1:0];
  endfunction

  logic [1:0]             state;
  logic [IDX_W-1:0]       idx;
  logic [15:0]            ts;
  logic signed [N-1:0]    i_cap;
  logic signed [N-1:0]    v_mem [NUM_NEURONS];
  logic signed [N-1:0]    w_mem [NUM_NEURONS];
  logic [RC_W-1:0]        rc_mem [NUM_NEURONS];

  logic signed [N-1:0]    v_cur, w_cur, acc, dv, dw, v_next, w_next, w_spk;
  logic [RC_W-1:0]        rc_cur;
  logic                   fire;

  assign v_cur  = v_mem[idx];
  assign w_cur  = w_mem[idx];
  assign rc_cur = rc_mem[idx];

  always_comb begin
    acc    = sat_add(mul_q(mul_q(K_004, v_cur), v_cur), mul_q(K_5, v_cur));
    acc    = sat_add(acc, K_140);
    acc    = sat_sub(acc, w_cur);
    acc    = sat_add(acc, i_cap);
    dv     = mul_q(step, acc);
    dw     = mul_q(step, mul_q(a, sat_sub(mul_q(b, v_cur), w_cur)));
    v_next = sat_add(v_cur, dv);
    w_next = sat_add(w_cur, dw);
    w_spk  = sat_add(w_cur, d);
    fire   = (rc_cur == '0) && (v_cur > $signed(v_th));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      ts    <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem[k]  <= v_init;
        w_mem[k]  <= w_init;
        rc_mem[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_FETCH;
          idx   <= '0;
        end
        S_FETCH: if (i_valid) begin
          i_cap <= i_data;
          state <= S_CALC;
        end
        S_CALC: begin
          if (rc_cur != '0) begin
            rc_mem[idx] <= rc_cur - 1'b1;
          end else if (fire) begin
            v_mem[idx]  <= c;
            w_mem[idx]  <= w_spk;
            rc_mem[idx] <= RC_W'(REFRAC_STEPS);
          end else begin
            v_mem[idx]  <= v_next;
            w_mem[idx]  <= w_next;
          end
          if (idx == LAST) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          ts    <= ts + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs are forced low while reset is held.
  assign i_req     = (state == S_FETCH) && !rst;
  assign i_idx     = idx;
  assign spike     = (state == S_CALC) && fire && !rst;
  assign spike_idx = idx;
  assign busy      = (state != S_IDLE) && !rst;
  assign done      = (state == S_DONE) && !rst;
  assign timestep  = ts;
  assign rd_v      = v_mem[rd_idx];
  assign rd_w      = w_mem[rd_idx];

endmodule

// File: tb/tb_izhikevich_array.sv
// Randomized scoreboard bench for izhikevich_array: a per-sweep reference model
// queues expected spike/done events, and a negedge monitor consumes them.
module tb_izhikevich_array;
  localparam int NN = 8;
  localparam int RS = 2;
  localparam int Q  = 16;

  logic        clk = 1'b0;
  logic        rst, start, i_valid;
  logic        i_req, spike, busy, done;
  logic [2:0]  i_idx, spike_idx, rd_idx;
  logic [15:0] timestep;
  logic [31:0] rd_v, rd_w, i_data;
  logic [31:0] v_init, w_init, v_th, step, a, b, c, d;

  int vi_c, wi_c, vth_c, st_c, a_c, b_c, c_c, d_c;
  int cur[NN];
  int mv[NN], mw[NN], mr[NN];
  int exp_ts;
  int checks = 0;
  int errors = 0;

  typedef struct { bit is_done; int idx; } ev_t;
  ev_t evq[$];

  assign v_init = vi_c;
  assign w_init = wi_c;
  assign v_th   = vth_c;
  assign step   = st_c;
  assign a      = a_c;
  assign b      = b_c;
  assign c      = c_c;
  assign d      = d_c;
  assign i_data = cur[i_idx];

  always #5 clk = ~clk;

  izhikevich_array #(.N(32), .Q(16), .NUM_NEURONS(NN), .REFRAC_STEPS(RS), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .v_init(v_init), .w_init(w_init),
    .v_th(v_th), .step(step), .a(a), .b(b), .c(c), .d(d),
    .i_req(i_req), .i_idx(i_idx), .i_data(i_data), .i_valid(i_valid),
    .spike(spike), .spike_idx(spike_idx), .busy(busy), .done(done),
    .timestep(timestep), .rd_idx(rd_idx), .rd_v(rd_v), .rd_w(rd_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Real-valued Izhikevich equations evaluated in Q16.16 with wide integers.
  function automatic int mulq(input int x, input int y);
    longint p;
    p = longint'(x) * longint'(y);
    return int'(p >>> Q);
  endfunction

  function automatic int satl(input longint s);
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return int'(s);
  endfunction

  function automatic void model_sweep();
    int k004, k5, k140, v, w, t, dv, dw;
    k004 = int'((64'sd4 <<< Q) / 100);
    k5   = 5 <<< Q;
    k140 = 140 <<< Q;
    for (int k = 0; k < NN; k++) begin
      v = mv[k];
      w = mw[k];
      if (mr[k] > 0) begin
        mr[k]--;
      end else if (v > vth_c) begin
        mv[k] = c_c;
        mw[k] = satl(longint'(w) + d_c);
        mr[k] = RS;
        evq.push_back('{1'b0, k});
      end else begin
        t  = satl(longint'(mulq(mulq(k004, v), v)) + mulq(k5, v));
        t  = satl(longint'(t) + k140);
        t  = satl(longint'(t) - w);
        t  = satl(longint'(t) + cur[k]);
        dv = mulq(st_c, t);
        dw = mulq(st_c, mulq(a_c, satl(longint'(mulq(b_c, v)) - w)));
        mv[k] = satl(longint'(v) + dv);
        mw[k] = satl(longint'(w) + dw);
      end
    end
    evq.push_back('{1'b1, 0});
    exp_ts = (exp_ts + 1) & 16'hFFFF;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (spike) begin
      if (evq.size() == 0) chk("spike_unexpected", {29'd0, spike_idx}, 32'hFFFF_FFFF);
      else begin
        e = evq.pop_front();
        chk("event_is_spike", 32'd0, {31'd0, e.is_done});
        chk("spike_idx", {29'd0, spike_idx}, e.idx);
      end
    end
    if (done) begin
      if (evq.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else begin
        e = evq.pop_front();
        chk("event_is_done", 32'd1, {31'd0, e.is_done});
      end
    end
  end

  task automatic check_state(input string tag);
    for (int k = 0; k < NN; k++) begin
      rd_idx = k[2:0];
      #0.5;
      chk({tag, "_rd_v"}, rd_v, mv[k]);
      chk({tag, "_rd_w"}, rd_w, mw[k]);
    end
  endtask

  task automatic do_reset(input int vi, input int wi);
    vi_c = vi; wi_c = wi;
    rst = 1'b1; start = 1'b1; i_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; i_valid = 1'b0;
    chk("rst_i_req", {31'd0, i_req}, 0);
    chk("rst_spike", {31'd0, spike}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NN; k++) begin mv[k] = vi; mw[k] = wi; mr[k] = 0; end
    exp_ts = 0;
    evq.delete();
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_i_req", {31'd0, i_req}, 0);
    chk("post_rst_timestep", {16'd0, timestep}, 0);
    check_state("reset");
  endtask

  task automatic run_sweep(input int stall_idx, input int stall_n);
    int edges, nreq, stalls;
    bit got;
    model_sweep();
    i_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; nreq = 0; stalls = stall_n; got = 0;
    while (!got && edges < 400) begin
      if (i_req) begin
        if (i_idx == stall_idx[2:0] && stalls > 0) begin
          i_valid = 1'b0;
          stalls--;
          chk("stall_busy", {31'd0, busy}, 1);
        end else begin
          i_valid = 1'b1;
          chk("i_idx_order", {29'd0, i_idx}, nreq);
          nreq++;
        end
      end else begin
        i_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      edges++;
      if (done) got = 1;
    end
    i_valid = 1'b0;
    chk("done_latency", edges, 2 * NN + stall_n);
    chk("req_count", nreq, NN);
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, busy}, 0);
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("timestep", {16'd0, timestep}, exp_ts);
    check_state("sweep");
  endtask

  task automatic abort_sweep();
    int stalls, n;
    bit hit;
    for (int k = 0; k < NN; k++) cur[k] = 0;
    i_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stalls = 5; hit = 0; n = 0;
    while (!hit && n < 100) begin
      if (i_req && i_idx == 3'd3) begin
        hit = 1;
      end else begin
        if (i_req && i_idx == 3'd1 && stalls > 0) begin
          i_valid = 1'b0;
          start = (stalls == 3);
          stalls--;
        end else begin
          i_valid = 1'b1;
          start = 1'b0;
        end
        @(posedge clk); #1;
        n++;
        if (stalls > 0 && stalls < 5) begin
          chk("stall_i_req", {31'd0, i_req}, 1);
          chk("stall_start_ignored_idx", {29'd0, i_idx}, 1);
        end
        start = 1'b0;
      end
    end
    chk("abort_reached_idx3", {31'd0, hit}, 1);
    do_reset(vi_c, wi_c);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_busy", {31'd0, busy}, 0);
    end
  endtask

  task automatic set_default_consts();
    vth_c = 30 <<< Q; st_c = 32'h0000_8000; a_c = 1310; b_c = 13107;
    c_c = -65 <<< Q; d_c = 8 <<< Q;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; i_valid = 1'b0; rd_idx = '0;
    for (int k = 0; k < NN; k++) cur[k] = 0;
    set_default_consts();

    do_reset(32'hFFBF_0000, 32'hFFF3_0000);
    for (int k = 0; k < NN; k++) cur[k] = $urandom_range(0, 20 << Q);
    run_sweep(-1, 0);

    // Every neuron starts above threshold, then rests through the refractory window.
    do_reset(32'h0028_0000, 32'hFFF3_0000);
    for (int k = 0; k < NN; k++) cur[k] = 32'h0064_0000;
    run_sweep(-1, 0);
    rd_idx = 3'd5; #0.5;
    chk("spike_reset_v", rd_v, 32'hFFBF_0000);
    chk("spike_bump_w", rd_w, 32'hFFFB_0000);
    run_sweep(-1, 0);
    run_sweep(2, 3);
    rd_idx = 3'd0; #0.5;
    chk("refrac_hold_v", rd_v, 32'hFFBF_0000);
    chk("refrac_hold_w", rd_w, 32'hFFFB_0000);
    run_sweep(-1, 0);

    vth_c = 30 <<< Q;
    do_reset(30 <<< Q, 0);
    run_sweep(-1, 0);

    for (int r = 0; r < 6; r++) begin
      vth_c = int'($urandom_range(0, 60)) <<< Q;
      st_c  = $urandom_range(16'h1000, 16'hFFFF);
      a_c   = $urandom_range(0, 16'h2000);
      b_c   = $urandom_range(0, 16'h8000);
      c_c   = -int'($urandom_range(40, 80)) <<< Q;
      d_c   = $urandom_range(0, 10 << Q);
      if (r % 2 == 0) do_reset(int'($urandom_range(0, 120)) - 80 <<< Q, -int'($urandom_range(0, 20)) <<< Q);
      for (int k = 0; k < NN; k++) cur[k] = int'($urandom_range(0, 400 << Q)) - (200 <<< Q);
      run_sweep($urandom_range(0, NN - 1), $urandom_range(0, 4));
    end

    vth_c = 32'h7FFF_FFFF; st_c = 32'h0001_0000;
    do_reset(32'h7F00_0000, 0);
    for (int k = 0; k < NN; k++) cur[k] = 32'h7FFF_FFFF;
    run_sweep(-1, 0);
    rd_idx = 3'd7; #0.5;
    chk("sat_v_max", rd_v, 32'h7FFF_FFFF);

    set_default_consts();
    do_reset(32'hFFBF_0000, 32'hFFF3_0000);
    abort_sweep();
    chk("abort_timestep", {16'd0, timestep}, 0);
    for (int k = 0; k < NN; k++) cur[k] = $urandom_range(0, 10 << Q);
    run_sweep(4, 2);

    chk("queue_drained", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
